// File: rtl/act_pipeline.sv
// Three-stage activation pipeline (clamp/offset, multiply, scale/saturate) over LANES samples.
// Modes: ReLU, ReLU6, hard-sigmoid, hard-swish; mode is captured per beat at acceptance.
module act_pipeline #(
    parameter int DATA_WIDTH = 26,
    parameter int FRAC_BITS  = 9,
    parameter int OUT_WIDTH  = 14,
    parameter int OUT_FRAC   = 9,
    parameter int LANES      = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        cfg_we,
    input  logic [1:0]                  cfg_mode,
    output logic                        cfg_err,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [LANES*DATA_WIDTH-1:0] in_data,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [LANES*OUT_WIDTH-1:0]  out_data,
    output logic                        sat_sticky,
    input  logic                        sat_clr
);
    localparam int TW        = FRAC_BITS + 4;
    localparam int PW        = DATA_WIDTH + TW + 16;
    localparam int SH_RELU   = FRAC_BITS - OUT_FRAC;
    localparam int SH_HSIG   = FRAC_BITS + 16 - OUT_FRAC;
    localparam int SH_HSWISH = 2 * FRAC_BITS + 16 - OUT_FRAC;

    localparam logic signed [PW-1:0] ZERO    = '0;
    localparam logic signed [PW-1:0] SIX     = PW'(6) <<< FRAC_BITS;
    localparam logic signed [PW-1:0] THREE   = PW'(3) <<< FRAC_BITS;
    localparam logic signed [PW-1:0] K       = PW'(10923);
    localparam logic signed [PW-1:0] OUT_MAX = (PW'(1) <<< (OUT_WIDTH - 1)) - PW'(1);
    localparam logic signed [PW-1:0] OUT_MIN = -OUT_MAX - PW'(1);

    localparam logic [1:0] MODE_RELU   = 2'd0;
    localparam logic [1:0] MODE_RELU6  = 2'd1;
    localparam logic [1:0] MODE_HSIG   = 2'd2;
    localparam logic [1:0] MODE_HSWISH = 2'd3;

    logic                         s1_v_q, s1_v_d, s2_v_q, s2_v_d, s3_v_q, s3_v_d;
    logic [1:0]                   mode_q, mode_d, s1_mode_q, s2_mode_q;
    logic                         cfg_err_q, cfg_err_d, sat_q, sat_d;
    logic signed [DATA_WIDTH-1:0] s1_x_q [LANES];
    logic signed [DATA_WIDTH-1:0] s1_x_d [LANES];
    logic signed [TW-1:0]         s1_t_q [LANES];
    logic signed [TW-1:0]         s1_t_d [LANES];
    logic signed [PW-1:0]         s2_p_q [LANES];
    logic signed [PW-1:0]         s2_p_d [LANES];
    logic signed [OUT_WIDTH-1:0]  s3_r_q [LANES];
    logic signed [OUT_WIDTH-1:0]  s3_r_d [LANES];
    logic signed [PW-1:0]         in_ext [LANES];
    logic signed [PW-1:0]         t_sum  [LANES];
    logic signed [PW-1:0]         x_ext  [LANES];
    logic signed [PW-1:0]         t_ext  [LANES];
    logic signed [PW-1:0]         shifted [LANES];
    logic [LANES-1:0]             clip;
    logic                         advance, accept, cfg_ok;

    // S1: capture x and the offset/clamped term t.
    always_comb begin
        for (int l = 0; l < LANES; l++) begin
            s1_x_d[l] = in_data[l*DATA_WIDTH +: DATA_WIDTH];
            in_ext[l] = PW'(s1_x_d[l]);
            t_sum[l]  = in_ext[l] + THREE;
            if (t_sum[l] < ZERO) begin
                s1_t_d[l] = '0;
            end else if (t_sum[l] > SIX) begin
                s1_t_d[l] = TW'(SIX);
            end else begin
                s1_t_d[l] = TW'(t_sum[l]);
            end
        end
    end

    // S2: full-precision product (or clamped value for the ReLU modes).
    always_comb begin
        for (int l = 0; l < LANES; l++) begin
            x_ext[l] = PW'(s1_x_q[l]);
            t_ext[l] = PW'(s1_t_q[l]);
            case (s1_mode_q)
                MODE_RELU:  s2_p_d[l] = (x_ext[l] < ZERO) ? ZERO : x_ext[l];
                MODE_RELU6: begin
                    if (x_ext[l] < ZERO) begin
                        s2_p_d[l] = ZERO;
                    end else if (x_ext[l] > SIX) begin
                        s2_p_d[l] = SIX;
                    end else begin
                        s2_p_d[l] = x_ext[l];
                    end
                end
                MODE_HSIG:  s2_p_d[l] = t_ext[l] * K;
                default:    s2_p_d[l] = x_ext[l] * t_ext[l] * K;
            endcase
        end
    end

    // S3: mode-dependent arithmetic shift, then saturate to the output range.
    always_comb begin
        for (int l = 0; l < LANES; l++) begin
            case (s2_mode_q)
                MODE_HSIG:   shifted[l] = s2_p_q[l] >>> SH_HSIG;
                MODE_HSWISH: shifted[l] = s2_p_q[l] >>> SH_HSWISH;
                default:     shifted[l] = s2_p_q[l] >>> SH_RELU;
            endcase
            clip[l] = (shifted[l] > OUT_MAX) || (shifted[l] < OUT_MIN);
            if (shifted[l] > OUT_MAX) begin
                s3_r_d[l] = OUT_WIDTH'(OUT_MAX);
            end else if (shifted[l] < OUT_MIN) begin
                s3_r_d[l] = OUT_WIDTH'(OUT_MIN);
            end else begin
                s3_r_d[l] = OUT_WIDTH'(shifted[l]);
            end
        end
    end

    always_comb begin
        advance   = !s3_v_q || out_ready;
        accept    = in_valid && advance;
        cfg_ok    = cfg_we && !(s1_v_q || s2_v_q || s3_v_q) && !accept;
        mode_d    = cfg_ok ? cfg_mode : mode_q;
        cfg_err_d = cfg_we && !cfg_ok;
        s1_v_d    = advance ? in_valid : s1_v_q;
        s2_v_d    = advance ? s1_v_q : s2_v_q;
        s3_v_d    = advance ? s2_v_q : s3_v_q;
        // A clipping beat entering the output register wins over a concurrent clear.
        if (advance && s2_v_q && (|clip)) begin
            sat_d = 1'b1;
        end else if (sat_clr) begin
            sat_d = 1'b0;
        end else begin
            sat_d = sat_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_v_q    <= 1'b0;
            s2_v_q    <= 1'b0;
            s3_v_q    <= 1'b0;
            mode_q    <= MODE_HSWISH;
            s1_mode_q <= MODE_HSWISH;
            s2_mode_q <= MODE_HSWISH;
            cfg_err_q <= 1'b0;
            sat_q     <= 1'b0;
            s1_x_q    <= '{default: '0};
            s1_t_q    <= '{default: '0};
            s2_p_q    <= '{default: '0};
            s3_r_q    <= '{default: '0};
        end else begin
            s1_v_q    <= s1_v_d;
            s2_v_q    <= s2_v_d;
            s3_v_q    <= s3_v_d;
            mode_q    <= mode_d;
            cfg_err_q <= cfg_err_d;
            sat_q     <= sat_d;
            if (advance) begin
                s1_x_q    <= s1_x_d;
                s1_t_q    <= s1_t_d;
                s1_mode_q <= mode_q;
                s2_p_q    <= s2_p_d;
                s2_mode_q <= s1_mode_q;
                s3_r_q    <= s3_r_d;
            end
        end
    end

    always_comb begin
        out_data = '0;
        for (int l = 0; l < LANES; l++) begin
            out_data[l*OUT_WIDTH +: OUT_WIDTH] = s3_r_q[l];
        end
    end

    assign in_ready   = advance;
    assign out_valid  = s3_v_q;
    assign cfg_err    = cfg_err_q;
    assign sat_sticky = sat_q;

endmodule

// File: doc/act_pipeline.md
ACT_PIPELINE -- requirements
Module: act_pipeline

Interface
REQ-001 Parameter DATA_WIDTH, default 26, signed input sample width.
REQ-002 Parameter FRAC_BITS, default 9, input fractional bits.
REQ-003 Parameter OUT_WIDTH, default 14, signed output sample width.
REQ-004 Parameter OUT_FRAC, default 9, output fractional bits; OUT_FRAC <= FRAC_BITS SHALL hold.
REQ-005 Parameter LANES, default 4, parallel samples per beat.
REQ-006 Port clk  input  1  single clock; all logic on rising edge.
REQ-007 Port rst  input  1  reset, synchronous, active-high.
REQ-008 Port cfg_we  input  1  mode-write strobe.
REQ-009 Port cfg_mode  input  2  mode: 0 ReLU, 1 ReLU6, 2 hard-sigmoid, 3 hard-swish.
REQ-010 Port cfg_err  output  1  one-cycle pulse, rejected mode write.
REQ-011 Port in_valid  input  1  input beat valid.
REQ-012 Port in_ready  output  1  input beat accepted when in_valid && in_ready.
REQ-013 Port in_data  input  LANES*DATA_WIDTH  packed signed samples, lane 0 in LSBs.
REQ-014 Port out_valid  output  1  output beat valid.
REQ-015 Port out_ready  input  1  downstream accept.
REQ-016 Port out_data  output  LANES*OUT_WIDTH  packed signed results, lane 0 in LSBs.
REQ-017 Port sat_sticky  output  1  set when any lane saturated since reset or sat_clr.
REQ-018 Port sat_clr  input  1  clears sat_sticky.

Function
REQ-019 Three-stage pipeline (S1 clamp/offset, S2 multiply, S3 scale/saturate), each stage with its own valid bit.
REQ-020 advance = !out_valid || out_ready; all stages shift only when advance is 1; in_ready = advance (combinational).
REQ-021 Latency exactly 3 cycles from accepted beat to out_valid with no stall; throughput 1 beat/cycle.
REQ-022 While out_valid && !out_ready, out_data and out_valid SHALL hold stable; no beat lost or duplicated.
REQ-023 Per lane, with x in Q.FRAC_BITS, SIX = 6<<FRAC_BITS, THREE = 3<<FRAC_BITS, K = 10923, t = clamp(x+THREE, 0, SIX).
REQ-024 Mode 0: r = max(x,0) >>> (FRAC_BITS-OUT_FRAC).
REQ-025 Mode 1: r = clamp(x,0,SIX) >>> (FRAC_BITS-OUT_FRAC).
REQ-026 Mode 2: r = (t*K) >>> (FRAC_BITS+16-OUT_FRAC).
REQ-027 Mode 3: r = (x*t*K) >>> (2*FRAC_BITS+16-OUT_FRAC).
REQ-028 All intermediates full precision, no truncation before final shift; >>> is arithmetic (floor toward minus infinity).
REQ-029 r saturates to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1]; any clipping lane in a beat leaving S3 sets sat_sticky.
REQ-030 sat_clr and a saturation event in the same cycle: sat_sticky = 1 (set wins).
REQ-031 Mode register applies to whole pipeline; each beat is processed with the mode captured at acceptance (mode carried per stage).
REQ-032 cfg_we accepted only when all stage valids are 0 and no input beat accepted that cycle; new mode used from next accepted beat.
REQ-033 cfg_we otherwise: mode unchanged, cfg_err = 1 next cycle for one cycle.
REQ-034 Lanes independent; identical arithmetic per lane.

Reset
REQ-035 On rst=1 at clock edge: all stage valids 0, out_valid 0, out_data 0, mode = 3, sat_sticky 0, cfg_err 0.
REQ-036 Reset mid-operation discards all in-flight beats; in_ready = 1 the cycle after rst deasserts.
REQ-037 rst overrides cfg_we and sat events in the same cycle.

Verification (defaults, mode 3 unless stated)
REQ-038 Lanes x = -1024, -1536, 1536, 0 one beat, out_ready=1 -> 3 cycles later out_data lanes = -171, 0, 1536, 0; sat_sticky 0.
REQ-039 Mode 2, lane x = 0 -> 256; x = 2048 -> 512; x = -2048 -> 0.
REQ-040 Mode 0, lane x = 10240 -> 8191, sat_sticky 1; sat_clr pulse -> sat_sticky 0 next cycle.
REQ-041 Stream 8 beats, out_ready toggled 1/0 every 2 cycles -> all 8 results in order, out_data stable while stalled, in_ready low during stalls.
REQ-042 cfg_we with mode 1 while a beat in flight -> cfg_err pulse, mode stays 3; repeat when drained -> accepted, x = 4096 -> 3072.
REQ-043 rst asserted with 2 beats in flight -> out_valid 0, no stale beat emitted afterward, mode back to 3.
